// File: rtl/reciever_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reciever_pkg
//  Description : Shared types and constants for the bit-serial frame receiver.
//                - state_t          : receiver FSM states
//                - c_default_*_chr  : default start/end framing characters
//                - f_max            : elaboration-time helper for sizing
//  Revision    : 1.0  initial release
// ============================================================================
package reciever_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2,
        TRAIL   = 2'd3
    } state_t;

    // Framing characters shared with the transmit side of the link.
    localparam logic [7:0] c_default_start_chr = 8'hA5;
    localparam logic [7:0] c_default_end_chr   = 8'h5A;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reciever_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : reciever_out_slot
//  Description : One-entry valid/ready holding register for received payloads.
//                A push is accepted when the slot is empty or is being drained
//                in the same cycle; otherwise the pushed payload is dropped and
//                overrun pulses for one cycle.
//  Ports       : clk, reset      clock / synchronous active-high reset
//                push, push_data payload offered by the framer (1 cycle)
//                pkt_ready       downstream accept
//                pkt_data        held payload, stable while valid && !ready
//                pkt_valid       slot occupied
//                overrun         1-cycle pulse: offered payload was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module reciever_out_slot #(
    parameter int DATA_W = 56
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pkt_ready,
    output logic [DATA_W-1:0] pkt_data,
    output logic              pkt_valid,
    output logic              overrun
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              w_room;

    // Room exists if the slot is empty or its content leaves this cycle.
    assign w_room = !r_valid || pkt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (push && w_room) begin
                r_data  <= push_data;
                r_valid <= 1'b1;
            end else if (push) begin
                r_overrun <= 1'b1;
            end else if (r_valid && pkt_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pkt_data  = r_data;
    assign pkt_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/reciever_framer.sv
`default_nettype none
// ============================================================================
//  Module      : reciever_framer
//  Description : Parametrised bit-serial frame receiver. Hunts for START_CHR,
//                collects PAYLOAD_W bits (LSB first) plus an optional even
//                parity bit, then checks END_CHR. Good payloads go to a
//                one-entry valid/ready slot; framing/parity failures and
//                dropped frames are flagged with 1-cycle pulses.
//  Ports       : clk          sole clock
//                reset        synchronous, active-high
//                read         bit strobe, data_stream valid this cycle
//                clear        synchronous flush back to HUNT (slot kept)
//                data_stream  demodulated bit
//                pkt_data     payload, first-received bit = LSB
//                pkt_valid    slot holds a good payload
//                pkt_ready    downstream accept
//                frame_err    1-cycle pulse: end char mismatch or parity fail
//                overrun      1-cycle pulse: good frame dropped, slot full
//                busy         FSM not in HUNT
//  Revision    : 1.0  initial release
// ============================================================================
module reciever_framer
    import reciever_pkg::*;
#(
    parameter int                PAYLOAD_W = 56,
    parameter int                CHAR_W    = 8,
    parameter logic [CHAR_W-1:0] START_CHR = CHAR_W'(c_default_start_chr),
    parameter logic [CHAR_W-1:0] END_CHR   = CHAR_W'(c_default_end_chr),
    parameter bit                PARITY_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 clear,
    input  logic                 data_stream,
    output logic [PAYLOAD_W-1:0] pkt_data,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    // One counter serves both the payload and the trailing char, so it is
    // sized for whichever is longer.
    localparam int                c_cnt_w    = $clog2(f_max(PAYLOAD_W, CHAR_W) + 1);
    localparam logic [c_cnt_w-1:0] c_pay_last = c_cnt_w'(PAYLOAD_W - 1);
    localparam logic [c_cnt_w-1:0] c_chr_last = c_cnt_w'(CHAR_W - 1);

    state_t               r_state;
    logic [CHAR_W-1:0]    r_window;
    logic [PAYLOAD_W-1:0] r_shift;
    logic [CHAR_W-1:0]    r_end;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_par;
    logic                 r_bad;
    logic                 r_frame_err;

    logic [CHAR_W-1:0]    w_win_next;
    logic [PAYLOAD_W-1:0] w_shift_next;
    logic [CHAR_W-1:0]    w_end_next;
    logic                 w_last_trail;
    logic                 w_frame_good;
    logic                 w_push;

    // ------------------------------------------------------------------
    // Shift-right next values: the newest bit enters at the MSB, so after
    // N strobes the first-received bit sits at the LSB.
    // ------------------------------------------------------------------
    if (CHAR_W > 1) begin : g_char_wide
        assign w_win_next = {data_stream, r_window[CHAR_W-1:1]};
        assign w_end_next = {data_stream, r_end[CHAR_W-1:1]};
    end else begin : g_char_one
        assign w_win_next = data_stream;
        assign w_end_next = data_stream;
    end

    if (PAYLOAD_W > 1) begin : g_pay_wide
        assign w_shift_next = {data_stream, r_shift[PAYLOAD_W-1:1]};
    end else begin : g_pay_one
        assign w_shift_next = data_stream;
    end

    // The frame verdict is formed combinationally on the final end-char
    // strobe so the slot can capture the payload on that same edge.
    assign w_last_trail = read && !clear && (r_state == TRAIL) && (r_cnt == c_chr_last);
    assign w_frame_good = (w_end_next == END_CHR) && !r_bad;
    assign w_push       = w_last_trail && w_frame_good;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HUNT;
            r_window    <= '0;
            r_shift     <= '0;
            r_end       <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_bad       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_last_trail && !w_frame_good;
            if (clear) begin
                // Abort silently; the bit on this cycle (if any) is dropped.
                r_state  <= HUNT;
                r_window <= '0;
                r_cnt    <= '0;
                r_bad    <= 1'b0;
            end else if (read) begin
                case (r_state)
                    HUNT: begin
                        r_window <= w_win_next;
                        if (w_win_next == START_CHR) begin
                            r_state <= COLLECT;
                            r_cnt   <= '0;
                            r_par   <= 1'b0;
                            r_bad   <= 1'b0;
                        end
                    end
                    COLLECT: begin
                        r_shift <= w_shift_next;
                        r_par   <= r_par ^ data_stream;
                        if (r_cnt == c_pay_last) begin
                            r_cnt   <= '0;
                            r_state <= PARITY_EN ? PARITY : TRAIL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        // Even parity: payload ones plus this bit must be even.
                        if (r_par ^ data_stream) begin
                            r_bad <= 1'b1;
                        end
                        r_cnt   <= '0;
                        r_state <= TRAIL;
                    end
                    TRAIL: begin
                        r_end <= w_end_next;
                        if (r_cnt == c_chr_last) begin
                            // Fresh hunt: the end char must not seed a new start.
                            r_state  <= HUNT;
                            r_window <= '0;
                            r_cnt    <= '0;
                            r_bad    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                    end
                endcase
            end
        end
    end

    reciever_out_slot #(
        .DATA_W (PAYLOAD_W)
    ) u_out_slot (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (r_shift),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .overrun   (overrun)
    );

    assign frame_err = r_frame_err;
    assign busy      = (r_state != HUNT);

endmodule
`default_nettype wire

// File: tb/tb_reciever_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reciever_framer
//  Description : Directed self-checking bench for reciever_framer with
//                PAYLOAD_W=16, CHAR_W=8, START=A5, END=5A, even parity.
//                A frame-level reference model is compared against the DUT
//                every cycle; literal checks pin key results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reciever_framer;

    localparam int         PW         = 16;
    localparam int         CW         = 8;
    localparam int         FRAME_BITS = PW + 1 + CW;
    localparam logic [7:0] START      = 8'hA5;
    localparam logic [7:0] ENDC       = 8'h5A;

    logic          clk = 1'b0;
    logic          reset;
    logic          read;
    logic          clear;
    logic          data_stream;
    logic          pkt_ready;
    logic [PW-1:0] pkt_data;
    logic          pkt_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reciever_framer #(
        .PAYLOAD_W (PW),
        .CHAR_W    (CW),
        .START_CHR (START),
        .END_CHR   (ENDC),
        .PARITY_EN (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .read        (read),
        .clear       (clear),
        .data_stream (data_stream),
        .pkt_data    (pkt_data),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level reference model: a history of the last CW bits for the
    // start search, then a list of frame bits judged as a whole.
    // ------------------------------------------------------------------
    bit            hist[$];
    bit            fbits[$];
    bit            in_frame;
    logic          m_valid;
    logic          m_ferr;
    logic          m_ovr;
    logic [PW-1:0] m_data;

    function automatic void hist_clear();
        hist.delete();
        for (int i = 0; i < CW; i++) hist.push_back(1'b0);
    endfunction

    task automatic model_step();
        logic          pop;
        logic          good_frame;
        logic [PW-1:0] pay;
        logic [7:0]    win;
        logic [7:0]    endv;
        int            ones;
        good_frame = 1'b0;
        pay        = '0;
        if (reset) begin
            m_valid  = 1'b0;
            m_ferr   = 1'b0;
            m_ovr    = 1'b0;
            m_data   = '0;
            in_frame = 1'b0;
            hist_clear();
            fbits.delete();
        end else begin
            pop    = m_valid && pkt_ready;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (clear) begin
                in_frame = 1'b0;
                hist_clear();
                fbits.delete();
            end else if (read) begin
                if (!in_frame) begin
                    hist.push_back(data_stream);
                    void'(hist.pop_front());
                    win = '0;
                    for (int i = 0; i < CW; i++) win[i] = hist[i];
                    if (win == START) begin
                        in_frame = 1'b1;
                        fbits.delete();
                    end
                end else begin
                    fbits.push_back(data_stream);
                    if (fbits.size() == FRAME_BITS) begin
                        ones = 0;
                        endv = '0;
                        for (int i = 0; i < PW; i++) begin
                            pay[i] = fbits[i];
                            ones += int'(fbits[i]);
                        end
                        ones += int'(fbits[PW]);
                        for (int i = 0; i < CW; i++) endv[i] = fbits[PW+1+i];
                        if ((ones % 2 == 0) && (endv == ENDC)) good_frame = 1'b1;
                        else m_ferr = 1'b1;
                        in_frame = 1'b0;
                        hist_clear();
                        fbits.delete();
                    end
                end
            end
            if (good_frame) begin
                if (!m_valid || pkt_ready) begin
                    m_data  = pay;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (pop) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Inputs change only at negedge+1, so at each negedge they still hold
    // the values sampled by the preceding posedge.
    initial begin
        in_frame = 1'b0;
        m_valid  = 1'b0;
        m_ferr   = 1'b0;
        m_ovr    = 1'b0;
        m_data   = '0;
        hist_clear();
        forever begin
            @(negedge clk);
            model_step();
            check("pkt_valid", 32'(pkt_valid), 32'(m_valid));
            check("pkt_data",  32'(pkt_data),  32'(m_data));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            check("overrun",   32'(overrun),   32'(m_ovr));
            check("busy",      32'(busy),      32'(in_frame));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        read        = 1'b1;
        data_stream = b;
        tick();
        read = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_char(input logic [7:0] c, input int gap);
        for (int i = 0; i < CW; i++) send_bit(c[i], gap);
    endtask

    // Final end-char strobe has no trailing gap so the caller can check
    // the outputs in the cycle right after it; pkt_ready is forced to
    // last_rdy for that strobe only.
    task automatic send_frame(input logic [PW-1:0] pay, input logic par,
                              input logic [7:0] endc, input int gap, input logic last_rdy);
        logic saved;
        send_char(START, gap);
        for (int i = 0; i < PW; i++) send_bit(pay[i], gap);
        send_bit(par, gap);
        for (int i = 0; i < CW - 1; i++) send_bit(endc[i], gap);
        saved     = pkt_ready;
        pkt_ready = last_rdy;
        send_bit(endc[CW-1], 0);
        pkt_ready = saved;
    endtask

    task automatic drain();
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        read        = 1'b0;
        clear       = 1'b0;
        data_stream = 1'b0;
        pkt_ready   = 1'b0;
        repeat (3) tick();
        check("reset_valid", 32'(pkt_valid), 32'd0);
        check("reset_data",  32'(pkt_data),  32'd0);
        check("reset_ferr",  32'(frame_err), 32'd0);
        check("reset_ovr",   32'(overrun),   32'd0);
        check("reset_busy",  32'(busy),      32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // 1: good frame with gaps between strobes
        send_frame(16'h1234, 1'b1, ENDC, 1, 1'b0);
        check("t1_valid", 32'(pkt_valid), 32'd1);
        check("t1_data",  32'(pkt_data),  32'h1234);
        check("t1_ferr",  32'(frame_err), 32'd0);
        drain();
        check("t1_drained", 32'(pkt_valid), 32'd0);

        // 2: wrong end char, then a good frame
        send_frame(16'h1234, 1'b1, 8'h5B, 0, 1'b0);
        check("t2_ferr",  32'(frame_err), 32'd1);
        check("t2_valid", 32'(pkt_valid), 32'd0);
        tick();
        check("t2_ferr_pulse", 32'(frame_err), 32'd0);
        send_frame(16'h00FF, 1'b0, ENDC, 0, 1'b0);
        check("t2_good_valid", 32'(pkt_valid), 32'd1);
        check("t2_good_data",  32'(pkt_data),  32'h00FF);
        drain();

        // 3: parity failure
        send_frame(16'h0001, 1'b0, ENDC, 0, 1'b0);
        check("t3_ferr",  32'(frame_err), 32'd1);
        check("t3_valid", 32'(pkt_valid), 32'd0);
        tick();

        // 4: overrun with the slot full
        send_frame(16'h1111, 1'b0, ENDC, 0, 1'b0);
        send_frame(16'h2222, 1'b0, ENDC, 0, 1'b0);
        check("t4_ovr",   32'(overrun),   32'd1);
        check("t4_data",  32'(pkt_data),  32'h1111);
        check("t4_valid", 32'(pkt_valid), 32'd1);
        tick();
        check("t4_ovr_pulse", 32'(overrun), 32'd0);
        drain();
        check("t4_drained", 32'(pkt_valid), 32'd0);

        // 5: refill on the same cycle the slot is drained
        send_frame(16'h1111, 1'b0, ENDC, 0, 1'b0);
        send_frame(16'h2222, 1'b0, ENDC, 0, 1'b1);
        check("t5_data",  32'(pkt_data),  32'h2222);
        check("t5_valid", 32'(pkt_valid), 32'd1);
        check("t5_ovr",   32'(overrun),   32'd0);
        drain();

        // 6: noise before start, clear mid-payload, then a good frame
        send_char(8'h3C, 0);
        send_char(8'hA4, 0);
        check("t6_noise_busy", 32'(busy), 32'd0);
        send_char(START, 0);
        check("t6_start_busy", 32'(busy), 32'd1);
        send_char(8'hFF, 0);
        clear       = 1'b1;
        read        = 1'b1;
        data_stream = 1'b1;
        tick();
        clear = 1'b0;
        read  = 1'b0;
        check("t6_clear_busy", 32'(busy),      32'd0);
        check("t6_clear_ferr", 32'(frame_err), 32'd0);
        send_frame(16'hBEEF, 1'b1, ENDC, 0, 1'b0);
        check("t6_valid", 32'(pkt_valid), 32'd1);
        check("t6_data",  32'(pkt_data),  32'hBEEF);

        // Reset mid-frame with the slot still full
        send_char(START, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 0);
        reset = 1'b1;
        tick();
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_data",  32'(pkt_data),  32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        reset = 1'b0;
        tick();
        send_frame(16'h1234, 1'b1, ENDC, 0, 1'b0);
        check("post_rst_data", 32'(pkt_data), 32'h1234);
        drain();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
